xorshift_cpu_multi: RTL
=======================

Name: xorshift_cpu_multi

Overview:
- Parametrised successor to the single-stream CPU traffic source.
- Runs NB_CHANNELS independent xorshift64 generators and selects between them with a round-robin arbiter.
- Buffers generated words in a DEPTH-entry FIFO and presents them on a valid/ready interface with a channel tag.
- Sits between the CPU core and the DPI client sender in each CPU top. The consumer may backpressure, which the previous block could not tolerate.

Parameters:
- CPU_INDEX, 0: CPU identifier; folded into every channel seed.
- NB_CHANNELS, 4: number of generator channels, 1..16.
- DEPTH, 8: output FIFO entries, power of two, >= 2.
- NB_TRANSACTIONS, 1000: total words issued per run, summed across all channels, >= 1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a run; ignored unless state is IDLE or DONE.
- data_vld  out  1  FIFO head valid.
- data_rdy  in  1  consumer accepts the head when data_vld && data_rdy.
- data  out  64  generated word.
- data_ch  out  max(1,$clog2(NB_CHANNELS))  channel that produced data.
- busy  out  1  high in RUN or DRAIN.
- issued_cnt  out  $clog2(NB_TRANSACTIONS+1)  words pushed into the FIFO this run.
- transactions_done  out  1  high in DONE.

Behaviour:
- Reset (async assert, released synchronously by the clock edge):
  - state=IDLE; all outputs 0; FIFO empty; arbiter pointer=0.
  - Channel c state = SEED(c) = 64'h9E3779B97F4A7C15 ^ {CPU_INDEX[31:0], c[31:0]}. If that value is 0, use 64'h1.
- FSM:
  - IDLE -start-> RUN.
  - RUN -(issued_cnt==NB_TRANSACTIONS)-> DRAIN.
  - DRAIN -(FIFO empty)-> DONE.
  - DONE -start-> RUN.
  - A start in DONE clears issued_cnt and the arbiter pointer. Channel states are NOT reseeded, so streams continue.
- Issue, in RUN only: when FIFO not full and issued_cnt < NB_TRANSACTIONS:
  - Push {ptr, state[ptr]}.
  - state[ptr] <= xs(state[ptr]), where xs is: x^=x<<13; x^=x>>7; x^=x<<17, all 64-bit, with shift-out discarded.
  - ptr <= (ptr==NB_CHANNELS-1) ? 0 : ptr+1; issued_cnt++.
  - The first word of each channel is therefore its seed.
- Fairness: with no backpressure, channels issue strictly in order 0,1,..,N-1,0,...; one word per cycle.
- Full FIFO: no issue, pointer holds, no generator advances. "Full" uses the registered count: a pop in the same cycle does not enable a push.
- FIFO:
  - Registered, not first-word-fall-through. A word pushed at edge k is visible on data/data_vld after edge k.
  - Push and pop in the same cycle keep the count unchanged.
  - data/data_ch stay stable while data_vld && !data_rdy.
  - Read and write pointers wrap modulo DEPTH.
- Latency: start at edge 0 → first push at edge 1 → data_vld high after edge 1.
- transactions_done stays high until the next start or rst. busy == (state ∈ {RUN, DRAIN}).
- start while in RUN or DRAIN: ignored, no effect.
- rst mid-run: immediate return to reset values; FIFO contents are discarded and data_vld drops asynchronously.

Optional Feature:
- Macro: XORSHIFT_CPU_MULTI_CHECKSUM_EN.
- Defined:
  - Adds output checksum[63:0]: the XOR of every popped data word this run; 0 at reset.
  - Cleared by an accepted start.
  - Updated on the edge where a pop occurs; the new value is visible the following cycle.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic order. NB_CHANNELS=4, CPU_INDEX=0, data_rdy=1, NB_TRANSACTIONS=8, pulse start:
  - data_ch sequence 0,1,2,3,0,1,2,3.
  - First word = 64'h9E3779B97F4A7C15.
  - Word 5 = xs(that seed).
  - transactions_done rises 2 cycles after the last push.
- Backpressure. data_rdy=0 for 20 cycles, DEPTH=8:
  - issued_cnt stalls at 8; data holds the first word.
  - After data_rdy=1, the remaining words continue in order with no loss or duplication against the reference model.
- Random stall. data_rdy toggled pseudo-randomly, NB_TRANSACTIONS=1000, NB_CHANNELS=3:
  - Scoreboard per-channel streams are exact.
  - Exactly 1000 pops; busy falls when transactions_done rises.
- Restart. After DONE, pulse start again with NB_TRANSACTIONS=4:
  - Channels resume from their advanced states, not from the seeds.
  - issued_cnt restarts at 0, then reaches 4.
- Reset mid-run. Assert rst at issued_cnt=5 with 3 words in the FIFO:
  - data_vld is 0 immediately; all outputs 0; state IDLE.
  - The next run's first word is again SEED(0).
- Checksum (macro defined). NB_TRANSACTIONS=8:
  - checksum equals the XOR of the 8 model words one cycle after the last pop.

Source files
------------

// File: rtl/xorshift_cpu_multi.sv
// Multi-channel xorshift64 traffic source: round-robin over NB_CHANNELS generators into a DEPTH-entry FIFO.
// Optional XORSHIFT_CPU_MULTI_CHECKSUM_EN adds a running XOR of every popped word.
module xorshift_cpu_multi #(
  parameter int CPU_INDEX       = 0,
  parameter int NB_CHANNELS     = 4,
  parameter int DEPTH           = 8,
  parameter int NB_TRANSACTIONS = 1000,
  localparam int CHW = (NB_CHANNELS > 1) ? $clog2(NB_CHANNELS) : 1,
  localparam int CW  = $clog2(NB_TRANSACTIONS + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           data_vld,
  input  logic           data_rdy,
  output logic [63:0]    data,
  output logic [CHW-1:0] data_ch,
  output logic           busy,
  output logic [CW-1:0]  issued_cnt,
`ifdef XORSHIFT_CPU_MULTI_CHECKSUM_EN
  output logic [63:0]    checksum,
`endif
  output logic           transactions_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = CHW + 64;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  function automatic logic [63:0] seed_of(input int c);
    logic [63:0] s;
    s = 64'h9E3779B97F4A7C15 ^ {32'(CPU_INDEX), 32'(c)};
    return (s == 64'd0) ? 64'd1 : s;
  endfunction

  function automatic logic [63:0] xs(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  state_t          r_fsm;
  logic            r_busy;
  logic            r_done;
  logic [CW-1:0]   r_issued;
  logic [CHW-1:0]  r_ptr;
  logic [63:0]     r_gen [NB_CHANNELS];
  logic [FW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_start_ok;
  logic [63:0]     w_cur;
  logic [FW-1:0]   w_head;

  assign w_full     = (r_count == (AW+1)'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push     = (r_fsm == S_RUN) && !w_full && (r_issued < CW'(NB_TRANSACTIONS));
  assign w_pop      = !w_empty && data_rdy;
  assign w_start_ok = start && ((r_fsm == S_IDLE) || (r_fsm == S_DONE));

  always_comb begin
    w_cur = '0;
    for (int c = 0; c < NB_CHANNELS; c++) begin
      if (r_ptr == CHW'(c)) w_cur = r_gen[c];
    end
  end

  // Control FSM, issue counter and arbiter pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm    <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_issued <= '0;
      r_ptr    <= '0;
    end else begin
      case (r_fsm)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_fsm    <= S_RUN;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_issued <= '0;
            r_ptr    <= '0;
          end
        end
        S_RUN: begin
          if (r_issued == CW'(NB_TRANSACTIONS)) r_fsm <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_empty) begin
            r_fsm  <= S_DONE;
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
        end
        default: r_fsm <= S_IDLE;
      endcase
      if (w_push) begin
        r_issued <= r_issued + 1'b1;
        r_ptr    <= (r_ptr == CHW'(NB_CHANNELS - 1)) ? '0 : r_ptr + 1'b1;
      end
    end
  end

  // Generators only step when their word is actually pushed; a restart does not reseed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NB_CHANNELS; c++) r_gen[c] <= seed_of(c);
    end else if (w_push) begin
      for (int c = 0; c < NB_CHANNELS; c++) begin
        if (r_ptr == CHW'(c)) r_gen[c] <= xs(r_gen[c]);
      end
    end
  end

  // FIFO bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {r_ptr, w_cur};
  end

  // Head is gated by valid so the outputs read zero while empty or in reset
  assign w_head            = r_mem[r_rptr];
  assign data_vld          = !w_empty;
  assign data              = data_vld ? w_head[63:0] : 64'd0;
  assign data_ch           = data_vld ? w_head[FW-1:64] : '0;
  assign busy              = r_busy;
  assign transactions_done = r_done;
  assign issued_cnt        = r_issued;

`ifdef XORSHIFT_CPU_MULTI_CHECKSUM_EN
  logic [63:0] r_checksum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_checksum <= '0;
    else if (w_start_ok) r_checksum <= '0;
    else if (w_pop)      r_checksum <= r_checksum ^ data;
  end

  assign checksum = r_checksum;
`else
  logic w_unused;
  assign w_unused = w_start_ok;
`endif

endmodule
